// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receive and transmit paths.
// Holds the frame FSM state encoding, the frame constants and the bit-period helper.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

    // Truncating division: the receiver samples mid-bit, so it tolerates the small rate error.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rxd_sync.sv
// Two-flop synchroniser for an asynchronous pad input.
// The reset value is a parameter so an idle-high line does not look like an edge after reset.
module rxd_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling FSM, shift register and a one-deep holding register.
// Framing errors and overruns are reported as one-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 416
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RXD,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_frame_err,
    output logic        rx_overrun,
    output uart_state_e dbg_state
);

    // Handshake: a byte transfers on any cycle with rx_valid & rx_ready; rx_valid and
    // rx_data stay stable until that cycle, and rx_ready while rx_valid=0 has no effect.

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e            r_state;
    uart_state_e            w_next_state;
    logic [BW-1:0]          r_baud;
    logic [2:0]             r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic w_rxs;
    logic w_half_tick;
    logic w_full_tick;
    logic w_baud_clr;
    logic w_shift_en;
    logic w_good;
    logic w_bad;

    rxd_sync #(.RESET_VAL(1'b1)) u_rxd_sync (
        .i_clk (CLK),
        .i_rst (RESET),
        .i_d   (RXD),
        .o_q   (w_rxs)
    );

    assign w_half_tick = (r_baud == HALF_M1);
    assign w_full_tick = (r_baud == FULL_M1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_baud_clr   = 1'b0;
        w_shift_en   = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_next_state = START;
                    w_baud_clr   = 1'b1;
                end
            end
            START: begin
                // A start bit that has gone high again by mid-bit was only a glitch.
                if (w_half_tick) begin
                    w_baud_clr   = 1'b1;
                    w_next_state = w_rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_full_tick) begin
                    w_baud_clr = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit == LAST_BIT) begin
                        w_next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (w_full_tick) begin
                    w_baud_clr = 1'b1;
                    if (w_rxs) begin
                        w_good       = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_bad        = 1'b1;
                        w_next_state = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (w_rxs) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (w_baud_clr || r_state == IDLE || r_state == WAIT_IDLE) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end

            if (r_state == IDLE) begin
                r_bit <= '0;
            end else if (w_shift_en && r_bit != LAST_BIT) begin
                r_bit <= r_bit + 1'b1;
            end

            if (w_shift_en) begin
                r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    // A byte being accepted this cycle frees the register for a frame completing in the same cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            r_overrun   <= 1'b0;
            if (w_good) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
// Frames are built from bytes bit by bit; delivered bytes are compared against an expected queue.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int N   = 16;
    localparam int LAT = 3 + N / 2 + 9 * N;

    logic        clk;
    logic        rst;
    logic        rxd;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_frame_err;
    logic        rx_overrun;
    uart_state_e dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_c0 = 0;
    int vhigh_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc_q[$];

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .CLK          (clk),
        .RESET        (rst),
        .RXD          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .dbg_state    (dbg_state)
    );

    // Clock / cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observer: records accepted bytes and pulse counts away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) vhigh_cnt <= vhigh_cnt + 1;
            if (rx_valid && rx_ready) begin
                got_q.push_back(rx_data);
                got_cyc_q.push_back(cyc);
            end
            if (rx_frame_err) fe_cnt <= fe_cnt + 1;
            if (rx_overrun) ov_cnt <= ov_cnt + 1;
        end
    end

    // Driver tasks: all leave the caller 1 time unit after a rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        rxd = 1'b0;
        last_c0 = cyc;
        wait_cyc(N);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(N);
        end
        rxd = stop_lvl;
        wait_cyc(N);
        rxd = 1'b1;
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        rx_ready = 1'b0;
        wait_cyc(2);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rx_valid); end
        checks++; if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses: got fe=%0b ov=%0b expected 0 0", rx_frame_err, rx_overrun); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
        rst = 1'b0;
        wait_cyc(4);
    endtask

    task automatic test_single();
        int v0, f0, o0;
        clear_obs();
        rx_ready = 1'b1;
        v0 = vhigh_cnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'hA5, 1'b1);
        wait_cyc(20);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d expected 1", got_q.size());
        end else begin
            checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", got_q[0]); end
            checks++; if (got_cyc_q[0] != last_c0 + LAT) begin errors++; $display("FAIL single_timing: got cycle %0d expected %0d", got_cyc_q[0], last_c0 + LAT); end
        end
        checks++; if (vhigh_cnt - v0 != 1) begin errors++; $display("FAIL single_valid_width: got %0d expected 1", vhigh_cnt - v0); end
        checks++; if (fe_cnt != f0 || ov_cnt != o0) begin errors++; $display("FAIL single_no_err: got fe=%0d ov=%0d expected 0 0", fe_cnt - f0, ov_cnt - o0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int f0, o0;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        clear_obs();
        f0 = fe_cnt; o0 = ov_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(bytes[i]);
            send_frame(bytes[i], 1'b1);
        end
        wait_cyc(20);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
            end
        end
        checks++; if (fe_cnt != f0 || ov_cnt != o0) begin errors++; $display("FAIL b2b_no_err: got fe=%0d ov=%0d expected 0 0", fe_cnt - f0, ov_cnt - o0); end
    endtask

    task automatic test_overrun();
        int o0;
        clear_obs();
        rx_ready = 1'b0;
        o0 = ov_cnt;
        send_frame(8'h3C, 1'b1);
        wait_cyc(5);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin errors++; $display("FAIL ovr_first: got v=%0b d=%0h expected 1 3c", rx_valid, rx_data); end
        send_frame(8'hC3, 1'b1);
        wait_cyc(5);
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL ovr_data_kept: got %0h expected 3c", rx_data); end
        checks++; if (ov_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulse: got %0d expected 1", ov_cnt - o0); end
        rx_ready = 1'b1;
        wait_cyc(1);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept_clear: got %0b expected 0", rx_valid); end
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin errors++; $display("FAIL ovr_accepted: got n=%0d expected one 3c", got_q.size()); end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        clear_obs();
        rxd = 1'b0;
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        v0 = vhigh_cnt; f0 = fe_cnt;
        wait_cyc(12 * N + 20);
        checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d expected 1", fe_cnt - f0); end
        checks++; if (dbg_state !== WAIT_IDLE) begin errors++; $display("FAIL ferr_state: got %0d expected %0d", dbg_state, WAIT_IDLE); end
        wait_cyc(15 * N);
        checks++; if (fe_cnt - f0 != 1 || vhigh_cnt != v0) begin errors++; $display("FAIL ferr_break_hold: got fe=%0d v=%0d expected 1 0", fe_cnt - f0, vhigh_cnt - v0); end
        rxd = 1'b1;
        wait_cyc(10);
        send_frame(8'h42, 1'b1);
        wait_cyc(20);
        checks++; if (got_q.size() != 1 || rx_data !== 8'h42) begin errors++; $display("FAIL ferr_recover: got n=%0d d=%0h expected 1 42", got_q.size(), rx_data); end
    endtask

    task automatic test_glitch();
        int v0, f0;
        clear_obs();
        v0 = vhigh_cnt; f0 = fe_cnt;
        rxd = 1'b0;
        wait_cyc(4);
        rxd = 1'b1;
        wait_cyc(2 * N);
        checks++; if (vhigh_cnt != v0 || fe_cnt != f0) begin errors++; $display("FAIL glitch_quiet: got v=%0d fe=%0d expected 0 0", vhigh_cnt - v0, fe_cnt - f0); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dbg_state, IDLE); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] partial;
        partial = 8'h5A;
        clear_obs();
        rxd = 1'b0;
        wait_cyc(N);
        for (int i = 0; i < 3; i++) begin
            rxd = partial[i];
            wait_cyc(N);
        end
        rxd = partial[3];
        wait_cyc(N / 2);
        rst = 1'b1;
        rxd = 1'b1;
        #1;
        checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out: got d=%0h v=%0b expected 00 0", rx_data, rx_valid); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d expected %0d", dbg_state, IDLE); end
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(10);
        send_frame(8'h81, 1'b1);
        wait_cyc(20);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h81) begin errors++; $display("FAIL rst_mid_next: got n=%0d expected one 81", got_q.size()); end
    endtask

    task automatic test_random();
        int f0, o0;
        logic [7:0] b;
        clear_obs();
        rx_ready = 1'b1;
        f0 = fe_cnt; o0 = ov_cnt;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            wait_cyc($urandom_range(0, 3 * N));
        end
        wait_cyc(20);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
            end
        end
        checks++; if (fe_cnt != f0 || ov_cnt != o0) begin errors++; $display("FAIL rand_no_err: got fe=%0d ov=%0d expected 0 0", fe_cnt - f0, ov_cnt - o0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
